// File: rtl/alu_if.sv
// ALU operand/command/result bundle.
//   master : drives CE, MODE, CMD, INP_VALID, OPA, OPB, CIN; observes RES and flags
//   slave  : the ALU side, consumes the request and drives RES, COUT, OFLOW, E, G, L, ERR
interface alu_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 3
);
  logic                 CE;
  logic                 MODE;
  logic [CMD_WIDTH:0]   CMD;
  logic [1:0]           INP_VALID;
  logic [WIDTH-1:0]     OPA;
  logic [WIDTH-1:0]     OPB;
  logic                 CIN;
  logic [WIDTH:0]       RES;
  logic                 COUT;
  logic                 OFLOW;
  logic                 E;
  logic                 G;
  logic                 L;
  logic                 ERR;

  modport master (
    output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    input  RES, COUT, OFLOW, E, G, L, ERR
  );

  modport slave (
    input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    output RES, COUT, OFLOW, E, G, L, ERR
  );
endinterface

// File: rtl/alu_core.sv
// Registered ALU with arithmetic and logical command sets and operand collection.
// Operands may arrive together or one at a time; a lone operand of a two-operand
// command is latched with the command and the ALU waits up to 16 enabled cycles
// for its partner before reporting ERR.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, wins over CE
//   bus  : alu_if slave (CE, MODE, CMD, INP_VALID, OPA, OPB, CIN in; RES and flags out)
module alu_core #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 3
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef logic [WIDTH:0]     res_t;
  typedef logic [WIDTH-1:0]   op_t;
  typedef logic [CMD_WIDTH:0] cmd_t;

  typedef struct packed {
    res_t res;
    logic cout;
    logic oflow;
    logic e;
    logic g;
    logic l;
    logic err;
  } out_t;

  typedef enum logic [1:0] {StIdle, StWaitA, StWaitB} state_e;

  // Returns {legal, need_a, need_b}.
  function automatic logic [2:0] decode(input logic mode, input cmd_t cmd);
    logic [31:0] c;
    logic [2:0]  d;
    c = 32'(cmd);
    if (mode) begin
      case (c)
        0, 1, 2, 3, 8: d = 3'b111;
        4, 5:          d = 3'b110;
        6, 7:          d = 3'b101;
        default:       d = 3'b000;
      endcase
    end else begin
      case (c)
        0, 1, 2, 3, 4, 5, 12, 13: d = 3'b111;
        6, 8, 9:                  d = 3'b110;
        7, 10, 11:                d = 3'b101;
        default:                  d = 3'b000;
      endcase
    end
    return d;
  endfunction

  function automatic out_t alu_eval(input logic mode, input cmd_t cmd, input op_t a,
                                    input op_t b, input logic cin);
    out_t        o;
    logic [31:0] c;
    res_t        ea, eb, ec;
    op_t         t;
    int unsigned s;
    o  = '0;
    c  = 32'(cmd);
    ea = res_t'(a);
    eb = res_t'(b);
    ec = res_t'(cin);
    t  = '0;
    s  = 32'(b[ShW-1:0]);
    if (mode) begin
      case (c)
        0: begin o.res = ea + eb;      o.cout  = o.res[WIDTH]; end
        1: begin o.res = ea - eb;      o.oflow = (ea < eb);    end
        2: begin o.res = ea + eb + ec; o.cout  = o.res[WIDTH]; end
        3: begin o.res = ea - eb - ec; o.oflow = (ea < eb + ec); end
        4: o.res = ea + res_t'(1);
        5: o.res = ea - res_t'(1);
        6: o.res = eb + res_t'(1);
        7: o.res = eb - res_t'(1);
        8: begin o.e = (a == b); o.g = (a > b); o.l = (a < b); end
        default: o.err = 1'b1;
      endcase
    end else begin
      case (c)
        0:  t = a & b;
        1:  t = ~(a & b);
        2:  t = a | b;
        3:  t = ~(a | b);
        4:  t = a ^ b;
        5:  t = ~(a ^ b);
        6:  t = ~a;
        7:  t = ~b;
        8:  t = a >> 1;
        9:  t = a << 1;
        10: t = b >> 1;
        11: t = b << 1;
        12: t = (a << s) | (a >> (WIDTH - s));
        13: t = (a >> s) | (a << (WIDTH - s));
        default: o.err = 1'b1;
      endcase
      // Rotate amounts beyond the operand width are rejected rather than wrapped.
      if ((c == 12 || c == 13) && (|b[WIDTH-1:ShW])) begin
        o.err = 1'b1;
        t     = '0;
      end
      o.res = res_t'(t);
    end
    return o;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_t        lat_a_q, lat_a_d;
  op_t        lat_b_q, lat_b_d;
  cmd_t       lat_cmd_q, lat_cmd_d;
  logic       lat_mode_q, lat_mode_d;
  logic       lat_cin_q, lat_cin_d;
  out_t       out_q, out_d;

  logic [2:0] dec;
  logic       ok_a, ok_b;
  out_t       timeout_out;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_a_d    = lat_a_q;
    lat_b_d    = lat_b_q;
    lat_cmd_d  = lat_cmd_q;
    lat_mode_d = lat_mode_q;
    lat_cin_d  = lat_cin_q;
    out_d      = out_q;

    dec  = decode(bus.MODE, bus.CMD);
    ok_a = !dec[1] || bus.INP_VALID[0];
    ok_b = !dec[0] || bus.INP_VALID[1];

    timeout_out     = '0;
    timeout_out.err = 1'b1;

    if (bus.CE) begin
      case (state_q)
        StIdle: begin
          if (bus.INP_VALID != 2'b00) begin
            if (!dec[2] || (ok_a && ok_b)) begin
              out_d = alu_eval(bus.MODE, bus.CMD, bus.OPA, bus.OPB, bus.CIN);
            end else if (dec[1] && dec[0]) begin
              // Exactly one operand of a two-operand command is present.
              lat_cmd_d  = bus.CMD;
              lat_mode_d = bus.MODE;
              lat_cin_d  = bus.CIN;
              cnt_d      = '0;
              if (bus.INP_VALID[0]) begin
                lat_a_d = bus.OPA;
                state_d = StWaitB;
              end else begin
                lat_b_d = bus.OPB;
                state_d = StWaitA;
              end
            end
          end
        end
        StWaitB: begin
          if (bus.INP_VALID[1]) begin
            out_d   = alu_eval(lat_mode_q, lat_cmd_q,
                               bus.INP_VALID[0] ? bus.OPA : lat_a_q, bus.OPB, lat_cin_q);
            state_d = StIdle;
          end else if (cnt_q == 4'd15) begin
            out_d   = timeout_out;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StWaitA: begin
          if (bus.INP_VALID[0]) begin
            out_d   = alu_eval(lat_mode_q, lat_cmd_q, bus.OPA,
                               bus.INP_VALID[1] ? bus.OPB : lat_b_q, lat_cin_q);
            state_d = StIdle;
          end else if (cnt_q == 4'd15) begin
            out_d   = timeout_out;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lat_a_q    <= '0;
      lat_b_q    <= '0;
      lat_cmd_q  <= '0;
      lat_mode_q <= 1'b0;
      lat_cin_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_a_q    <= lat_a_d;
      lat_b_q    <= lat_b_d;
      lat_cmd_q  <= lat_cmd_d;
      lat_mode_q <= lat_mode_d;
      lat_cin_q  <= lat_cin_d;
      out_q      <= out_d;
    end
  end

  assign bus.RES   = out_q.res;
  assign bus.COUT  = out_q.cout;
  assign bus.OFLOW = out_q.oflow;
  assign bus.E     = out_q.e;
  assign bus.G     = out_q.g;
  assign bus.L     = out_q.l;
  assign bus.ERR   = out_q.err;

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter: WIDTH, default 8, operand width.
REQ-002 Parameter: CMD_WIDTH, default 3; CMD is CMD_WIDTH+1 bits.
REQ-003 Port: clk  input  1  single clock, all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: CE  input  1  clock enable; 0 freezes all state and outputs.
REQ-006 Port: MODE  input  1  1 = arithmetic command set, 0 = logical command set.
REQ-007 Port: CMD  input  CMD_WIDTH+1  command code.
REQ-008 Port: INP_VALID  input  2  bit0 = OPA valid, bit1 = OPB valid.
REQ-009 Port: OPA, OPB  input  WIDTH  operands.
REQ-010 Port: CIN  input  1  carry/borrow in.
REQ-011 Port: RES  output  WIDTH+1  registered result.
REQ-012 Port: COUT, OFLOW, E, G, L, ERR  output  1 each  registered flags.

Function
REQ-013 Arithmetic set (MODE=1): 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP; other codes are illegal.
REQ-014 Logical set (MODE=0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B; other codes are illegal.
REQ-015 Operand need: INC_A/DEC_A/NOT_A/SHx1_A need only OPA; INC_B/DEC_B/NOT_B/SHx1_B need only OPB; all other legal commands need both operands.
REQ-016 FSM states: IDLE, WAIT_A, WAIT_B.
- IDLE: required operands all valid -> compute.
- IDLE: two-operand command with INP_VALID=01 -> latch OPA, CMD, MODE, CIN; go to WAIT_B.
- IDLE: two-operand command with INP_VALID=10 -> latch OPB, CMD, MODE, CIN; go to WAIT_A.
- IDLE: INP_VALID=00 -> stay, outputs hold.
REQ-017 In WAIT_x, the missing operand's valid bit at 1 -> compute with the latched operand, the arriving operand and the latched command; return to IDLE. INP_VALID=11 in WAIT_x uses both new operands.
REQ-018 CMD, MODE and CIN are ignored in WAIT_x; the latched values apply.
REQ-019 Wait counter: resets to 0 on entering WAIT_x and increments per CE=1 cycle. At 16 cycles without completion: RES=0, ERR=1, all other flags 0; return to IDLE.
REQ-020 Latency: results are registered on the edge that samples the completing operand and are visible the following cycle. Outputs hold until the next result or reset.
REQ-021 Width rules:
- ADD/ADD_CIN: RES = A+B(+CIN), full WIDTH+1 bits; COUT=RES[WIDTH].
- SUB/SUB_CIN: RES = A-B(-CIN) mod 2^(WIDTH+1); OFLOW=1 when the unsigned result is negative.
- INC/DEC: WIDTH+1-bit result, no flags.
- Logical ops: RES[WIDTH]=0.
REQ-022 CMP: RES=0; exactly one of E (A==B), G (A>B), L (A<B) is 1, unsigned compare. E/G/L are 0 for all other commands.
REQ-023 Shifts: one position, zero fill. ROL/ROR rotate OPA by OPB[log2(WIDTH)-1:0]. Any higher OPB bit set -> ERR=1, RES=0.
REQ-024 Illegal command: ERR=1, RES=0, other flags 0, one-cycle latency; legal results drive ERR=0.
REQ-025 CE=0: FSM, latches, wait counter and outputs all frozen; inputs ignored.

Reset
REQ-026 rst=1 on a clock edge forces state IDLE, wait counter 0, latches 0, RES=0 and all flags 0. rst has priority over CE.
REQ-027 Reset mid-wait discards the pending operand; the next valid input starts a fresh operation.

Verification
REQ-028 MODE=1, CMD=0, INP_VALID=11, OPA=200, OPB=100 -> next cycle RES=9'h12C, COUT=1, ERR=0.
REQ-029 MODE=1, CMD=1, OPA=5, OPB=10, INP_VALID=11 -> RES=9'h1FB, OFLOW=1.
REQ-030 ADD: cycle 0 INP_VALID=01 OPA=3; cycles 1-4 INP_VALID=00; cycle 5 INP_VALID=10 OPB=4 -> cycle 6 RES=7; outputs unchanged during cycles 1-5.
REQ-031 ADD: INP_VALID=01, then 16 CE=1 cycles of 00 -> ERR=1, RES=0. Repeat with CE=0 for 5 of those cycles -> timeout delayed by 5 cycles.
REQ-032 CMP with OPA=OPB=7 -> E=1, G=0, L=0. ROL_A_B with OPB=8'h10 -> ERR=1. MODE=1, CMD=12 -> ERR=1.
REQ-033 rst asserted in WAIT_B -> all outputs 0; a subsequent INP_VALID=10 alone enters WAIT_A and does not complete the old operation.
